// File: rtl/x_pcie_sync_evt_rx.sv
// Slow-domain event receiver: each synchronized-level edge becomes a pulse plus a pending count per bit.
// Latency: 1 s_clk from sampled edge to evt_pulse/evt_pend; evt_valid is a combinational compare of the count.
// Backpressure: valid/ready per bit; the counter saturates while the consumer stalls and sets a sticky overflow flag.
module x_pcie_sync_evt_rx #(
  parameter int WIDTH     = 1,
  parameter int CNT_W     = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic                   s_clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_sync,
  output logic [WIDTH-1:0]       evt_pulse,
  output logic [WIDTH-1:0]       evt_valid,
  input  logic [WIDTH-1:0]       evt_ready,
  output logic [WIDTH*CNT_W-1:0] evt_pend,
  output logic [WIDTH-1:0]       evt_ovf,
  input  logic [WIDTH-1:0]       ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                         r_armed;
  logic [WIDTH-1:0]             r_prev;
  logic [WIDTH-1:0]             r_pulse;
  logic [WIDTH-1:0]             r_ovf;
  logic [WIDTH-1:0][CNT_W-1:0]  r_cnt;

  logic [WIDTH-1:0]             w_det;
  logic [WIDTH-1:0]             w_pop;
  logic [WIDTH-1:0]             w_ovf_set;
  logic [WIDTH-1:0]             w_valid;
  logic [WIDTH-1:0][CNT_W-1:0]  w_cnt_nxt;

  // Edge detect; suppressed until the first post-reset sample has seeded r_prev,
  // so a level already high out of reset is never counted.
  always_comb begin
    if (!r_armed) begin
      w_det = '0;
    end else if (EDGE_MODE == 1) begin
      w_det = in_sync & ~r_prev;
    end else begin
      w_det = in_sync ^ r_prev;
    end
  end

  // Valid is just "count non-zero"; a ready without valid never pops.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_valid[i] = (r_cnt[i] != '0);
    end
  end

  assign w_pop = w_valid & evt_ready;

  // Next count per bit: a simultaneous edge and pop cancel, even at saturation.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_det[i] && !w_pop[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else if (!w_det[i] && w_pop[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Arming flag, previous-level sample and the event pulse.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_prev  <= '0;
      r_pulse <= '0;
    end else begin
      r_armed <= 1'b1;
      r_prev  <= in_sync;
      r_pulse <= w_det;
    end
  end

  // Pending counters and sticky overflow; a new overflow beats a clear in the same cycle.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= (r_ovf & ~ovf_clr) | w_ovf_set;
    end
  end

  assign evt_pulse = r_pulse;
  assign evt_valid = w_valid;
  assign evt_pend  = r_cnt;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_x_pcie_sync_evt_rx.sv
// Bench for x_pcie_sync_evt_rx: two instances (both-edge and rising-only) share stimulus,
// a count-based reference model is compared on every cycle, and directed steps pin known values.
module tb_x_pcie_sync_evt_rx;

  logic       s_clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_sync;
  logic [1:0] evt_ready;
  logic [1:0] ovf_clr;

  logic [1:0] pulse0, valid0, ovf0, pulse1, valid1, ovf1;
  logic [7:0] pend0, pend1;

  logic [1:0] o_pulse [2];
  logic [1:0] o_valid [2];
  logic [1:0] o_ovf   [2];
  logic [7:0] o_pend  [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: plain integer counts per instance and bit.
  int m_cnt   [2][2];
  bit m_prev  [2][2];
  bit m_ovf   [2][2];
  bit m_pulse [2][2];
  bit m_armed;

  always #5 s_clk = ~s_clk;

  x_pcie_sync_evt_rx #(.WIDTH(2), .CNT_W(4), .EDGE_MODE(0)) u_dut0 (
    .s_clk(s_clk), .rst_n(rst_n), .in_sync(in_sync),
    .evt_pulse(pulse0), .evt_valid(valid0), .evt_ready(evt_ready),
    .evt_pend(pend0), .evt_ovf(ovf0), .ovf_clr(ovf_clr)
  );

  x_pcie_sync_evt_rx #(.WIDTH(2), .CNT_W(4), .EDGE_MODE(1)) u_dut1 (
    .s_clk(s_clk), .rst_n(rst_n), .in_sync(in_sync),
    .evt_pulse(pulse1), .evt_valid(valid1), .evt_ready(evt_ready),
    .evt_pend(pend1), .evt_ovf(ovf1), .ovf_clr(ovf_clr)
  );

  assign o_pulse[0] = pulse0;
  assign o_pulse[1] = pulse1;
  assign o_valid[0] = valid0;
  assign o_valid[1] = valid1;
  assign o_ovf[0]   = ovf0;
  assign o_ovf[1]   = ovf1;
  assign o_pend[0]  = pend0;
  assign o_pend[1]  = pend1;

  task automatic chk(input string nm, input int d, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d bit%0d: got %0d expected %0d at %0t", nm, d, i, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    chk(nm, 0, 0, act, exp);
  endtask

  // Model: count = count + event - pop, clipped at 15 with the overflow flag set on clipping.
  always @(posedge s_clk) begin
    int det, pop, n;
    bit rise, fall;
    if (!rst_n) begin
      m_armed = 1'b0;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[d][i] = 0; m_prev[d][i] = 1'b0; m_ovf[d][i] = 1'b0; m_pulse[d][i] = 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2; i++) begin
          rise = in_sync[i] && !m_prev[d][i];
          fall = !in_sync[i] && m_prev[d][i];
          det  = (m_armed && (rise || (d == 0 && fall))) ? 1 : 0;
          pop  = (m_cnt[d][i] > 0 && evt_ready[i]) ? 1 : 0;
          n    = m_cnt[d][i] + det - pop;
          if (ovf_clr[i]) m_ovf[d][i] = 1'b0;
          if (n > 15) begin
            n = 15;
            m_ovf[d][i] = 1'b1;
          end
          m_cnt[d][i]   = n;
          m_pulse[d][i] = (det != 0);
          m_prev[d][i]  = in_sync[i];
        end
      end
      m_armed = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge s_clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        chk("pulse", d, i, int'(o_pulse[d][i]), int'(m_pulse[d][i]));
        chk("valid", d, i, int'(o_valid[d][i]), (m_cnt[d][i] > 0) ? 1 : 0);
        chk("pend",  d, i, int'(o_pend[d][i*4 +: 4]), m_cnt[d][i]);
        chk("ovf",   d, i, int'(o_ovf[d][i]), int'(m_ovf[d][i]));
      end
    end
  end

  task automatic nxt();
    @(negedge s_clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_sync = 2'b11; evt_ready = 2'b00; ovf_clr = 2'b00;
    repeat (3) nxt();

    // Level high out of reset is never counted.
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      nxt();
      lit("hi_rst_pulse0", int'(pulse0), 0);
      lit("hi_rst_pend0",  int'(pend0), 0);
      lit("hi_rst_valid1", int'(valid1), 0);
    end

    // Fresh reset with low input, then arming cycle.
    rst_n = 1'b0; in_sync = 2'b00;
    nxt();
    rst_n = 1'b1;
    nxt();

    // 0->1->0 on bit 0 with 3-cycle spacing, consumer stalled.
    in_sync = 2'b01;
    nxt();
    lit("rise_pulse0", int'(pulse0[0]), 1);
    lit("rise_pulse1", int'(pulse1[0]), 1);
    lit("rise_valid0", int'(valid0[0]), 1);
    nxt();
    lit("rise_pulse0_gone", int'(pulse0[0]), 0);
    nxt();
    in_sync = 2'b00;
    nxt();
    lit("fall_pulse0", int'(pulse0[0]), 1);
    lit("fall_pulse1", int'(pulse1[0]), 0);
    nxt(); nxt();
    lit("two_evt_pend0", int'(pend0[3:0]), 2);
    lit("one_evt_pend1", int'(pend1[3:0]), 1);

    // Drain.
    evt_ready = 2'b01;
    nxt();
    lit("pop1_pend0",  int'(pend0[3:0]), 1);
    lit("pop1_valid1", int'(valid1[0]), 0);
    nxt();
    lit("pop2_pend0",  int'(pend0[3:0]), 0);
    lit("pop2_valid0", int'(valid0[0]), 0);
    evt_ready = 2'b00;

    // Saturate: 16 rising edges.
    for (int k = 0; k < 16; k++) begin
      in_sync = 2'b01; nxt();
      in_sync = 2'b00; nxt();
    end
    lit("sat_pend1", int'(pend1[3:0]), 15);
    lit("sat_ovf1",  int'(ovf1[0]), 1);
    lit("sat_pend0", int'(pend0[3:0]), 15);

    // Clear together with a new overflow: set wins.
    in_sync = 2'b01; ovf_clr = 2'b01;
    nxt();
    lit("clr_vs_set_ovf1", int'(ovf1[0]), 1);
    ovf_clr = 2'b00;
    nxt();
    ovf_clr = 2'b01;
    nxt();
    lit("clr_alone_ovf1", int'(ovf1[0]), 0);
    lit("clr_alone_ovf0", int'(ovf0[0]), 0);
    ovf_clr = 2'b00;

    // Edge and pop at max: count stays, no overflow.
    in_sync = 2'b00;
    nxt();
    in_sync = 2'b01; evt_ready = 2'b01;
    nxt();
    lit("max_pop_pend1", int'(pend1[3:0]), 15);
    lit("max_pop_ovf1",  int'(ovf1[0]), 0);
    lit("max_pop_pend0", int'(pend0[3:0]), 15);
    lit("max_pop_ovf0",  int'(ovf0[0]), 1);
    evt_ready = 2'b00;

    // Mid-stream reset.
    in_sync = 2'b11;
    nxt();
    lit("b1_pend0", int'(pend0[7:4]), 1);
    rst_n = 1'b0;
    nxt();
    lit("mrst_pend0",  int'(pend0), 0);
    lit("mrst_pend1",  int'(pend1), 0);
    lit("mrst_valid0", int'(valid0), 0);
    lit("mrst_ovf0",   int'(ovf0), 0);
    rst_n = 1'b1; in_sync = 2'b00;
    nxt();
    lit("arm_pulse0", int'(pulse0), 0);
    lit("arm_pend0",  int'(pend0), 0);
    in_sync = 2'b01;
    nxt();
    lit("post_arm_pend0", int'(pend0[3:0]), 1);
    lit("post_arm_pulse0", int'(pulse0), 1);

    // Random traffic, occasional resets and clears.
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      in_sync   = in_sync ^ (($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
      evt_ready = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      ovf_clr   = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      nxt();
    end

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
